stacktr_ctrl: RTL and testbench

- Upstream controller for the stack trace buffer RAM.
- Watches committed call/return instructions from the execute stage and maintains a circular call stack of {npc, pc} pairs.
- Drives the buffer write port and owns the buffer read address for debug-port queries, indexed from top of stack.
- One instance per River core; sits between the execute/commit stage, the DPort CSR logic and the stack trace buffer RAM.

---
 rtl/stacktr_ctrl_pkg.sv | 33 +++
 rtl/stacktr_ctrl_if.sv | 23 ++
 rtl/stacktr_ctrl.sv | 103 ++++++++++
 tb/tb_stacktr_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stacktr_ctrl_pkg.sv
// Shared sizes, FSM state and register bundle for the stack trace controller.
// Sizes mirror the River core configuration (stack trace address width, XLEN).
package stacktr_ctrl_pkg;

   localparam int CFG_LOG2_STACK_TRACE_ADDR = 5;
   localparam int RISCV_ARCH = 64;

   localparam int abits = CFG_LOG2_STACK_TRACE_ADDR;
   localparam int dbits = 2 * RISCV_ARCH;
   localparam int SIZE  = 1 << abits;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   typedef struct packed {
      logic [abits-1:0] wptr;
      logic [abits:0]   depth;
      logic             overflow;
      state_t           state;
      logic             err_q;
   } stacktr_ctrl_registers;

   localparam stacktr_ctrl_registers stacktr_ctrl_r_reset = '{
      wptr:     '0,
      depth:    '0,
      overflow: 1'b0,
      state:    IDLE,
      err_q:    1'b0
   };

endpackage

// File: rtl/stacktr_ctrl_if.sv
// Debug-port query channel into the stack trace controller.
// master = DPort CSR side, slave = stacktr_ctrl.
interface stacktr_ctrl_if;
   import stacktr_ctrl_pkg::*;

   logic             req_valid;
   logic [abits-1:0] idx;
   logic             req_ready;
   logic             resp_valid;
   logic [dbits-1:0] resp_data;
   logic             resp_err;

   modport master (
      output req_valid, idx,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, idx,
      output req_ready, resp_valid, resp_data, resp_err
   );

endinterface

// File: rtl/stacktr_ctrl.sv
// Call-stack tracker: turns committed call/ret into ring-buffer writes of {npc,pc}
// and serves top-of-stack-relative debug reads from the external buffer RAM.
module stacktr_ctrl
   import stacktr_ctrl_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_e_valid,
   input  logic                  i_e_call,
   input  logic                  i_e_ret,
   input  logic [RISCV_ARCH-1:0] i_e_pc,
   input  logic [RISCV_ARCH-1:0] i_e_npc,
   input  logic                  i_clear,
   stacktr_ctrl_if.slave         dport,
   output logic [abits:0]        o_depth,
   output logic                  o_overflow,
   output logic                  o_we,
   output logic [abits-1:0]      o_waddr,
   output logic [dbits-1:0]      o_wdata,
   output logic [abits-1:0]      o_raddr,
   input  logic [dbits-1:0]      i_rdata
);

   localparam logic [abits:0] FULL_DEPTH = (abits+1)'(SIZE);

   stacktr_ctrl_registers r, v;

   logic push;
   logic pop;
   logic tail;

   function automatic logic [abits:0] depth_sat_inc(input logic [abits:0] d);
      return (d == FULL_DEPTH) ? d : d + 1'b1;
   endfunction

   always_comb begin
      v       = r;
      o_we    = 1'b0;
      o_waddr = r.wptr;
      o_wdata = {i_e_npc, i_e_pc};
      o_raddr = r.wptr - 1'b1;

      dport.req_ready  = 1'b0;
      dport.resp_valid = 1'b0;
      dport.resp_data  = '0;
      dport.resp_err   = 1'b0;

      // A tail call on an empty stack has nothing to replace, so it pushes.
      push = i_e_valid & i_e_call & (~i_e_ret | (r.depth == '0));
      tail = i_e_valid & i_e_call & i_e_ret & (r.depth != '0);
      pop  = i_e_valid & i_e_ret & ~i_e_call;

      if (i_clear) begin
         v.wptr     = '0;
         v.depth    = '0;
         v.overflow = 1'b0;
      end else if (push) begin
         o_we   = 1'b1;
         v.wptr = r.wptr + 1'b1;
         v.depth = depth_sat_inc(r.depth);
         if (r.depth == FULL_DEPTH) begin
            v.overflow = 1'b1;
         end
      end else if (tail) begin
         o_we    = 1'b1;
         o_waddr = r.wptr - 1'b1;
      end else if (pop && (r.depth != '0)) begin
         v.wptr  = r.wptr - 1'b1;
         v.depth = r.depth - 1'b1;
      end

      // Reads see the stack as it was before this cycle's push/pop/clear.
      case (r.state)
         IDLE: begin
            dport.req_ready = 1'b1;
            if (dport.req_valid) begin
               o_raddr = r.wptr - 1'b1 - dport.idx;
               v.err_q = ({1'b0, dport.idx} >= r.depth);
               v.state = RESP;
            end
         end
         RESP: begin
            dport.resp_valid = 1'b1;
            dport.resp_err   = r.err_q;
            dport.resp_data  = r.err_q ? '0 : i_rdata;
            v.state          = IDLE;
         end
         default: v.state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r <= stacktr_ctrl_r_reset;
      end else begin
         r <= v;
      end
   end

   assign o_depth    = r.depth;
   assign o_overflow = r.overflow;

endmodule

// File: tb/tb_stacktr_ctrl.sv
// Directed + random bench for stacktr_ctrl against a queue-based call-stack model
// with a write-first buffer RAM model attached to the write/read ports.
module tb_stacktr_ctrl;
   import stacktr_ctrl_pkg::*;

   logic i_clk = 1'b0;
   logic i_nrst = 1'b0;
   always #5 i_clk = ~i_clk;

   logic                  e_valid, e_call, e_ret, clr;
   logic [RISCV_ARCH-1:0] e_pc, e_npc;
   logic [abits:0]        o_depth;
   logic                  o_overflow, o_we;
   logic [abits-1:0]      o_waddr, o_raddr;
   logic [dbits-1:0]      o_wdata, rdata;

   stacktr_ctrl_if dp();

   stacktr_ctrl dut (
      .i_clk      (i_clk),
      .i_nrst     (i_nrst),
      .i_e_valid  (e_valid),
      .i_e_call   (e_call),
      .i_e_ret    (e_ret),
      .i_e_pc     (e_pc),
      .i_e_npc    (e_npc),
      .i_clear    (clr),
      .dport      (dp.slave),
      .o_depth    (o_depth),
      .o_overflow (o_overflow),
      .o_we       (o_we),
      .o_waddr    (o_waddr),
      .o_wdata    (o_wdata),
      .o_raddr    (o_raddr),
      .i_rdata    (rdata)
   );

   // Buffer RAM: write-first so a read sees the same-cycle write.
   logic [dbits-1:0] mem [SIZE];
   initial begin
      for (int i = 0; i < SIZE; i++) mem[i] = '0;
      rdata = '0;
   end
   always @(posedge i_clk) begin
      if (o_we) mem[o_waddr] = o_wdata;
      rdata <= mem[o_raddr];
   end

   int n_assert = 0;
   int n_fail = 0;

   logic [dbits-1:0] stk[$];
   int               ptr = 0;
   bit               ovf = 0;
   bit               pend = 0;
   bit               pend_err = 0;
   logic [dbits-1:0] pend_data = '0;

   task automatic chk(input string tag, input logic [dbits-1:0] obs, input logic [dbits-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap(input int a);
      return (a + 4 * SIZE) % SIZE;
   endfunction

   task automatic step(input bit v, input bit c, input bit r,
                       input logic [RISCV_ARCH-1:0] pc, input logic [RISCV_ARCH-1:0] npc,
                       input bit cl, input bit rq, input int idx);
      logic [dbits-1:0] nd;
      bit do_push, do_tail, do_pop, acc;
      int sz;
      @(posedge i_clk);
      #1;
      e_valid = v; e_call = c; e_ret = r; e_pc = pc; e_npc = npc; clr = cl;
      dp.req_valid = rq; dp.idx = idx[abits-1:0];
      #1;
      sz = stk.size();
      nd = {npc, pc};
      chk("depth", o_depth, sz);
      chk("overflow", o_overflow, ovf);
      chk("resp_valid", dp.resp_valid, pend);
      chk("req_ready", dp.req_ready, !pend);
      if (pend) begin
         chk("resp_err", dp.resp_err, pend_err);
         chk("resp_data", dp.resp_data, pend_data);
      end
      do_push = v && c && (!r || sz == 0);
      do_tail = v && c && r && sz > 0;
      do_pop  = v && r && !c;
      if (cl) chk("we_clear", o_we, 0);
      else if (do_push) begin
         chk("we_push", o_we, 1);
         chk("waddr_push", o_waddr, ptr);
         chk("wdata_push", o_wdata, nd);
      end else if (do_tail) begin
         chk("we_tail", o_we, 1);
         chk("waddr_tail", o_waddr, wrap(ptr - 1));
         chk("wdata_tail", o_wdata, nd);
      end else chk("we_idle", o_we, 0);
      acc = rq && !pend;
      if (acc) begin
         chk("raddr_req", o_raddr, wrap(ptr - 1 - idx));
         pend_err = (idx >= sz);
         pend_data = pend_err ? '0 : stk[sz-1-idx];
         if (!cl && do_tail && idx == 0) pend_data = nd;
         if (!cl && do_push && sz == SIZE && idx == SIZE - 1) pend_data = nd;
      end else if (!pend) begin
         chk("raddr_idle", o_raddr, wrap(ptr - 1));
      end
      pend = acc;
      if (cl) begin
         stk.delete(); ptr = 0; ovf = 0;
      end else if (do_push) begin
         stk.push_back(nd);
         if (stk.size() > SIZE) begin
            void'(stk.pop_front());
            ovf = 1;
         end
         ptr = wrap(ptr + 1);
      end else if (do_tail) begin
         stk[sz-1] = nd;
      end else if (do_pop && sz > 0) begin
         void'(stk.pop_back());
         ptr = wrap(ptr - 1);
      end
   endtask

   task automatic idle();
      step(0, 0, 0, '0, '0, 0, 0, 0);
   endtask
   task automatic push(input logic [RISCV_ARCH-1:0] pc);
      step(1, 1, 0, pc, pc + 64'h40, 0, 0, 0);
   endtask
   task automatic ret();
      step(1, 0, 1, '0, '0, 0, 0, 0);
   endtask
   task automatic rd(input int idx);
      step(0, 0, 0, '0, '0, 0, 1, idx);
   endtask
   task automatic clear();
      step(0, 0, 0, '0, '0, 1, 0, 0);
   endtask

   initial begin
      e_valid = 0; e_call = 0; e_ret = 0; e_pc = '0; e_npc = '0; clr = 0;
      dp.req_valid = 0; dp.idx = '0;
      #3;
      chk("rst_we", o_we, 0);
      chk("rst_resp_valid", dp.resp_valid, 0);
      chk("rst_req_ready", dp.req_ready, 1);
      chk("rst_depth", o_depth, 0);
      chk("rst_overflow", o_overflow, 0);
      #9 i_nrst = 1'b1;

      // Three pushes, top-of-stack read
      push(64'h100); push(64'h200); push(64'h300);
      rd(0); idle();
      chk("t1_data", pend_data, {64'h340, 64'h300});

      // Push 3, ret 2, then valid and out-of-range reads
      clear(); push(64'h100); push(64'h200); push(64'h300); ret(); ret();
      rd(0); idle(); rd(1); idle();

      // Wrap past full depth
      clear();
      for (int i = 1; i <= 33; i++) push(64'(i * 16));
      rd(31); idle(); rd(0); idle();

      // Ret on empty stack
      clear(); ret(); idle(); rd(0); idle();

      // Tail call at depth 2, with a same-cycle read of the top
      clear(); push(64'h100); push(64'h200);
      step(1, 1, 1, 64'h500, 64'h540, 0, 1, 0); idle();
      rd(1); idle();

      // Clear alongside a push while a response is pending
      clear(); push(64'h100); rd(0);
      step(1, 1, 0, 64'h900, 64'h940, 1, 0, 0);
      idle();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         bit v, c, r, cl, rq;
         int k;
         v = ($urandom_range(0, 3) != 0);
         k = $urandom_range(0, 9);
         c = (k < 5) || (k == 9);
         r = (k >= 5);
         cl = ($urandom_range(0, 63) == 0);
         rq = ($urandom_range(0, 2) == 0);
         step(v, c, r, {$urandom, $urandom}, {$urandom, $urandom}, cl, rq,
              $urandom_range(0, SIZE - 1));
      end
      idle(); idle();

      // Asynchronous reset while a response is pending
      push(64'hA00); rd(0);
      @(posedge i_clk);
      #1;
      dp.req_valid = 0; e_valid = 0; clr = 0;
      i_nrst = 1'b0;
      #1;
      chk("arst_resp_valid", dp.resp_valid, 0);
      chk("arst_req_ready", dp.req_ready, 1);
      chk("arst_depth", o_depth, 0);
      chk("arst_we", o_we, 0);
      stk.delete(); ptr = 0; ovf = 0; pend = 0;
      @(negedge i_clk);
      i_nrst = 1'b1;
      push(64'hB00); rd(0); idle(); rd(1); idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
